// File: rtl/transfer_out_arbiter.sv
// Arbitrates the byte-wide Transfer Out channel between 4-byte control frames and single data bytes.
// Four-phase SEND/DONE per byte; round-robin on contention; watchdog aborts a stalled handshake.
module transfer_out_arbiter #(
    parameter logic [7:0] HDR_BYTE1      = 8'h5A,
    parameter logic [7:0] HDR_BYTE2      = 8'hC3,
    parameter logic [7:0] HDR_BYTE3      = 8'h7E,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CFG_REQ,
    input  logic [7:0] CFG_BYTE,
    output logic       CFG_ACK,
    input  logic       DATA_VALID,
    input  logic [7:0] DATA_BYTE,
    output logic       DATA_READY,
    output logic       TRANSFER_OUT_SEND,
    output logic [7:0] TRANSFER_OUT_BYTE,
    input  logic       TRANSFER_OUT_DONE,
    output logic       BUSY,
    output logic       TIMEOUT_ERR,
    input  logic       ERR_CLEAR
);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR1, S_HDR2, S_HDR3, S_CFG, S_DATA
    } state_t;

    state_t          state;
    logic            releasing;
    logic [WD_W-1:0] wd;
    logic            last_cfg;

    assign BUSY = (state != S_IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state             <= S_IDLE;
            releasing         <= 1'b0;
            wd                <= '0;
            last_cfg          <= 1'b0;
            CFG_ACK           <= 1'b0;
            DATA_READY        <= 1'b0;
            TRANSFER_OUT_SEND <= 1'b0;
            TRANSFER_OUT_BYTE <= 8'h00;
            TIMEOUT_ERR       <= 1'b0;
        end else begin
            CFG_ACK    <= 1'b0;
            DATA_READY <= 1'b0;
            // A watchdog set later in this block overrides the clear.
            if (ERR_CLEAR)
                TIMEOUT_ERR <= 1'b0;

            if (state == S_IDLE) begin
                wd        <= '0;
                releasing <= 1'b0;
                // Grant only once DONE is low so a stale acknowledge is never taken for the new byte.
                if (!TRANSFER_OUT_DONE && (CFG_REQ || DATA_VALID)) begin
                    TRANSFER_OUT_SEND <= 1'b1;
                    if (CFG_REQ && (!DATA_VALID || !last_cfg)) begin
                        state             <= S_HDR1;
                        TRANSFER_OUT_BYTE <= HDR_BYTE1;
                    end else begin
                        state             <= S_DATA;
                        TRANSFER_OUT_BYTE <= DATA_BYTE;
                    end
                end
            end else if (wd == WD_MAX) begin
                state             <= S_IDLE;
                TRANSFER_OUT_SEND <= 1'b0;
                releasing         <= 1'b0;
                wd                <= '0;
                TIMEOUT_ERR       <= 1'b1;
            end else if (!releasing) begin
                if (TRANSFER_OUT_DONE) begin
                    releasing         <= 1'b1;
                    TRANSFER_OUT_SEND <= 1'b0;
                    wd                <= '0;
                end else begin
                    wd <= wd + 1'b1;
                end
            end else if (!TRANSFER_OUT_DONE) begin
                releasing <= 1'b0;
                wd        <= '0;
                case (state)
                    S_HDR1: begin
                        state             <= S_HDR2;
                        TRANSFER_OUT_BYTE <= HDR_BYTE2;
                        TRANSFER_OUT_SEND <= 1'b1;
                    end
                    S_HDR2: begin
                        state             <= S_HDR3;
                        TRANSFER_OUT_BYTE <= HDR_BYTE3;
                        TRANSFER_OUT_SEND <= 1'b1;
                    end
                    S_HDR3: begin
                        state             <= S_CFG;
                        TRANSFER_OUT_BYTE <= CFG_BYTE;
                        TRANSFER_OUT_SEND <= 1'b1;
                    end
                    S_CFG: begin
                        state    <= S_IDLE;
                        CFG_ACK  <= 1'b1;
                        last_cfg <= 1'b1;
                    end
                    S_DATA: begin
                        state      <= S_IDLE;
                        DATA_READY <= 1'b1;
                        last_cfg   <= 1'b0;
                    end
                    default: state <= S_IDLE;
                endcase
            end else begin
                wd <= wd + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_transfer_out_arbiter.sv
// Directed bench: scripted responder on the Transfer Out channel, byte log, per-scenario checks.
module tb_transfer_out_arbiter;
    logic       CLK = 1'b0;
    logic       RST;
    logic       CFG_REQ;
    logic [7:0] CFG_BYTE;
    logic       CFG_ACK;
    logic       DATA_VALID;
    logic [7:0] DATA_BYTE;
    logic       DATA_READY;
    logic       TRANSFER_OUT_SEND;
    logic [7:0] TRANSFER_OUT_BYTE;
    logic       TRANSFER_OUT_DONE;
    logic       BUSY;
    logic       TIMEOUT_ERR;
    logic       ERR_CLEAR;

    int checks   = 0;
    int failures = 0;
    logic       stall_hdr2 = 1'b0;
    logic [7:0] byte_log[$];

    transfer_out_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .CLK(CLK), .RST(RST),
        .CFG_REQ(CFG_REQ), .CFG_BYTE(CFG_BYTE), .CFG_ACK(CFG_ACK),
        .DATA_VALID(DATA_VALID), .DATA_BYTE(DATA_BYTE), .DATA_READY(DATA_READY),
        .TRANSFER_OUT_SEND(TRANSFER_OUT_SEND), .TRANSFER_OUT_BYTE(TRANSFER_OUT_BYTE),
        .TRANSFER_OUT_DONE(TRANSFER_OUT_DONE), .BUSY(BUSY),
        .TIMEOUT_ERR(TIMEOUT_ERR), .ERR_CLEAR(ERR_CLEAR)
    );

    always #5 CLK = ~CLK;

    // Responder: raises DONE after seeing SEND for 3 cycles, drops it once SEND falls.
    initial begin
        int cnt;
        cnt = 0;
        TRANSFER_OUT_DONE = 1'b0;
        forever begin
            @(negedge CLK);
            if (!TRANSFER_OUT_DONE) begin
                if (TRANSFER_OUT_SEND && !(stall_hdr2 && TRANSFER_OUT_BYTE == 8'hC3)) begin
                    cnt++;
                    if (cnt >= 3) begin
                        TRANSFER_OUT_DONE = 1'b1;
                        cnt = 0;
                    end
                end else begin
                    cnt = 0;
                end
            end else if (!TRANSFER_OUT_SEND) begin
                TRANSFER_OUT_DONE = 1'b0;
            end
        end
    end

    // Logs the byte presented at each rising edge of SEND.
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge CLK);
            if (TRANSFER_OUT_SEND && !prev)
                byte_log.push_back(TRANSFER_OUT_BYTE);
            prev = TRANSFER_OUT_SEND;
        end
    end

    task automatic test_reset;
        RST = 1'b1; CFG_REQ = 1'b0; CFG_BYTE = 8'h00; DATA_VALID = 1'b0;
        DATA_BYTE = 8'h00; ERR_CLEAR = 1'b0;
        repeat (3) @(negedge CLK);
        checks++; if (TRANSFER_OUT_SEND !== 1'b0) begin failures++; $display("FAIL reset_send got=%b exp=0", TRANSFER_OUT_SEND); end
        checks++; if (TRANSFER_OUT_BYTE !== 8'h00) begin failures++; $display("FAIL reset_byte got=%h exp=00", TRANSFER_OUT_BYTE); end
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
        checks++; if (CFG_ACK !== 1'b0) begin failures++; $display("FAIL reset_cfg_ack got=%b exp=0", CFG_ACK); end
        checks++; if (DATA_READY !== 1'b0) begin failures++; $display("FAIL reset_data_ready got=%b exp=0", DATA_READY); end
        checks++; if (TIMEOUT_ERR !== 1'b0) begin failures++; $display("FAIL reset_timeout_err got=%b exp=0", TIMEOUT_ERR); end
        RST = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_cfg_frame;
        logic [7:0] exp_q[$];
        int acks, busy_seen;
        exp_q = '{8'h5A, 8'hC3, 8'h7E, 8'hA5};
        acks = 0; busy_seen = 0;
        byte_log.delete();
        CFG_BYTE = 8'hA5; CFG_REQ = 1'b1;
        for (int c = 0; c < 300 && acks == 0; c++) begin
            @(negedge CLK);
            if (BUSY) busy_seen++;
            if (CFG_ACK) begin acks++; CFG_REQ = 1'b0; end
        end
        repeat (10) begin @(negedge CLK); if (CFG_ACK) acks++; end
        checks++; if (acks != 1) begin failures++; $display("FAIL cfg_ack_count got=%0d exp=1", acks); end
        checks++; if (busy_seen == 0) begin failures++; $display("FAIL cfg_busy_during got=0 exp=>0"); end
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL cfg_busy_after got=%b exp=0", BUSY); end
        checks++; if (byte_log.size() != 4) begin failures++; $display("FAIL cfg_len got=%0d exp=4", byte_log.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (byte_log.size() <= i || byte_log[i] !== exp_q[i]) begin
                failures++; $display("FAIL cfg_byte%0d got=%h exp=%h", i, (byte_log.size() > i) ? byte_log[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_q[$];
        int readys, idle_gaps;
        exp_q = '{8'h11, 8'h22, 8'h33};
        readys = 0; idle_gaps = 0;
        byte_log.delete();
        DATA_BYTE = 8'h11; DATA_VALID = 1'b1;
        for (int c = 0; c < 600 && readys < 3; c++) begin
            @(negedge CLK);
            if (!BUSY && !TRANSFER_OUT_SEND) idle_gaps++;
            if (DATA_READY) begin
                readys++;
                if (readys == 1) DATA_BYTE = 8'h22;
                else if (readys == 2) DATA_BYTE = 8'h33;
                else DATA_VALID = 1'b0;
            end
        end
        DATA_VALID = 1'b0;
        repeat (10) begin @(negedge CLK); if (DATA_READY) readys++; end
        checks++; if (readys != 3) begin failures++; $display("FAIL b2b_ready_count got=%0d exp=3", readys); end
        checks++; if (idle_gaps < 3) begin failures++; $display("FAIL b2b_idle_gaps got=%0d exp=>=3", idle_gaps); end
        checks++; if (byte_log.size() != 3) begin failures++; $display("FAIL b2b_len got=%0d exp=3", byte_log.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (byte_log.size() <= i || byte_log[i] !== exp_q[i]) begin
                failures++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, (byte_log.size() > i) ? byte_log[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_round_robin;
        logic [7:0] exp_q[$];
        int acks, readys;
        exp_q = '{8'h5A, 8'hC3, 8'h7E, 8'h3C, 8'h44, 8'h5A, 8'hC3, 8'h7E, 8'h3C, 8'h44};
        acks = 0; readys = 0;
        RST = 1'b1;
        CFG_BYTE = 8'h3C; CFG_REQ = 1'b1; DATA_BYTE = 8'h44; DATA_VALID = 1'b1;
        repeat (2) @(negedge CLK);
        byte_log.delete();
        RST = 1'b0;
        for (int c = 0; c < 1500 && readys < 2; c++) begin
            @(negedge CLK);
            if (CFG_ACK) acks++;
            if (DATA_READY) begin
                readys++;
                if (readys == 2) begin CFG_REQ = 1'b0; DATA_VALID = 1'b0; end
            end
        end
        CFG_REQ = 1'b0; DATA_VALID = 1'b0;
        repeat (10) @(negedge CLK);
        checks++; if (acks != 2) begin failures++; $display("FAIL rr_ack_count got=%0d exp=2", acks); end
        checks++; if (byte_log.size() != 10) begin failures++; $display("FAIL rr_len got=%0d exp=10", byte_log.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (byte_log.size() <= i || byte_log[i] !== exp_q[i]) begin
                failures++; $display("FAIL rr_byte%0d got=%h exp=%h", i, (byte_log.size() > i) ? byte_log[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_mid_frame_data;
        logic [7:0] exp_q[$];
        int acks, readys;
        exp_q = '{8'h5A, 8'hC3, 8'h7E, 8'h96, 8'h77};
        acks = 0; readys = 0;
        byte_log.delete();
        CFG_BYTE = 8'h96; CFG_REQ = 1'b1;
        for (int c = 0; c < 300 && !(TRANSFER_OUT_SEND && TRANSFER_OUT_BYTE == 8'hC3); c++)
            @(negedge CLK);
        DATA_BYTE = 8'h77; DATA_VALID = 1'b1;
        for (int c = 0; c < 600 && readys == 0; c++) begin
            @(negedge CLK);
            if (CFG_ACK) begin acks++; CFG_REQ = 1'b0; end
            if (DATA_READY) begin
                readys++; DATA_VALID = 1'b0;
                checks++; if (acks != 1) begin failures++; $display("FAIL mid_ack_before_ready got=%0d exp=1", acks); end
            end
        end
        CFG_REQ = 1'b0; DATA_VALID = 1'b0;
        repeat (5) @(negedge CLK);
        checks++; if (readys != 1) begin failures++; $display("FAIL mid_ready_count got=%0d exp=1", readys); end
        checks++; if (byte_log.size() != 5) begin failures++; $display("FAIL mid_len got=%0d exp=5", byte_log.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (byte_log.size() <= i || byte_log[i] !== exp_q[i]) begin
                failures++; $display("FAIL mid_byte%0d got=%h exp=%h", i, (byte_log.size() > i) ? byte_log[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_timeout;
        logic [7:0] exp_q[$];
        int high_cycles, acks;
        exp_q = '{8'h5A, 8'hC3, 8'h5A, 8'hC3, 8'h7E, 8'h5C};
        high_cycles = 0; acks = 0;
        byte_log.delete();
        stall_hdr2 = 1'b1;
        CFG_BYTE = 8'h5C; CFG_REQ = 1'b1;
        for (int c = 0; c < 300 && !(TRANSFER_OUT_SEND && TRANSFER_OUT_BYTE == 8'hC3); c++)
            @(negedge CLK);
        if (TRANSFER_OUT_SEND) high_cycles = 1;
        for (int c = 0; c < 100 && TRANSFER_OUT_SEND; c++) begin
            @(negedge CLK);
            if (TRANSFER_OUT_SEND) high_cycles++;
            if (CFG_ACK) acks++;
        end
        checks++; if (high_cycles != 16) begin failures++; $display("FAIL to_send_high_cycles got=%0d exp=16", high_cycles); end
        checks++; if (TIMEOUT_ERR !== 1'b1) begin failures++; $display("FAIL to_err_set got=%b exp=1", TIMEOUT_ERR); end
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL to_busy_after_abort got=%b exp=0", BUSY); end
        checks++; if (acks != 0) begin failures++; $display("FAIL to_no_ack got=%0d exp=0", acks); end
        stall_hdr2 = 1'b0;
        for (int c = 0; c < 300 && acks == 0; c++) begin
            @(negedge CLK);
            if (CFG_ACK) begin acks++; CFG_REQ = 1'b0; end
        end
        CFG_REQ = 1'b0;
        repeat (3) @(negedge CLK);
        checks++; if (byte_log.size() != 6) begin failures++; $display("FAIL to_len got=%0d exp=6", byte_log.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (byte_log.size() <= i || byte_log[i] !== exp_q[i]) begin
                failures++; $display("FAIL to_byte%0d got=%h exp=%h", i, (byte_log.size() > i) ? byte_log[i] : 8'hxx, exp_q[i]);
            end
        end
        checks++; if (TIMEOUT_ERR !== 1'b1) begin failures++; $display("FAIL to_err_sticky got=%b exp=1", TIMEOUT_ERR); end
        ERR_CLEAR = 1'b1;
        @(negedge CLK);
        ERR_CLEAR = 1'b0;
        checks++; if (TIMEOUT_ERR !== 1'b0) begin failures++; $display("FAIL to_err_clear got=%b exp=0", TIMEOUT_ERR); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] exp_q[$];
        int acks;
        exp_q = '{8'h5A, 8'hC3, 8'h7E, 8'hE1};
        acks = 0;
        CFG_BYTE = 8'hE1; CFG_REQ = 1'b1;
        for (int c = 0; c < 300 && !(TRANSFER_OUT_SEND && TRANSFER_OUT_BYTE == 8'hE1); c++) begin
            @(negedge CLK);
            if (CFG_ACK) acks++;
        end
        checks++; if (TRANSFER_OUT_SEND !== 1'b1) begin failures++; $display("FAIL rm_send_in_cfg got=%b exp=1", TRANSFER_OUT_SEND); end
        #2 RST = 1'b1;
        #1;
        checks++; if (TRANSFER_OUT_SEND !== 1'b0) begin failures++; $display("FAIL rm_send_async got=%b exp=0", TRANSFER_OUT_SEND); end
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL rm_busy_async got=%b exp=0", BUSY); end
        checks++; if (CFG_ACK !== 1'b0) begin failures++; $display("FAIL rm_ack_async got=%b exp=0", CFG_ACK); end
        @(negedge CLK);
        byte_log.delete();
        RST = 1'b0;
        for (int c = 0; c < 300 && acks == 0; c++) begin
            @(negedge CLK);
            if (CFG_ACK) begin acks++; CFG_REQ = 1'b0; end
        end
        CFG_REQ = 1'b0;
        repeat (3) @(negedge CLK);
        checks++; if (acks != 1) begin failures++; $display("FAIL rm_ack_count got=%0d exp=1", acks); end
        checks++; if (byte_log.size() != 4) begin failures++; $display("FAIL rm_len got=%0d exp=4", byte_log.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (byte_log.size() <= i || byte_log[i] !== exp_q[i]) begin
                failures++; $display("FAIL rm_byte%0d got=%h exp=%h", i, (byte_log.size() > i) ? byte_log[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cfg_frame();
        test_back_to_back();
        test_round_robin();
        test_mid_frame_data();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
